// File: rtl/data_matrix_rr_pkg.sv
// Shared constants and helpers for the data_matrix_rr crossbar.
// Policy encodings and the modulo-m pointer advance used by the top level.
package data_matrix_rr_pkg;

    localparam int POLICY_STALL = 0;
    localparam int POLICY_DROP  = 1;

    // Explicit wrap keeps the pointer below m when m is not a power of two.
    function automatic int next_ptr(input int idx, input int m);
        return (idx >= m - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/data_matrix_rr_if.sv
// RX FIFO bank / LUT / TX bus bundle for data_matrix_rr.
// master = surrounding FIFO logic, slave = the crossbar.
interface data_matrix_rr_if #(
    parameter int m = 8,
    parameter int n = 8,
    parameter int o = 8
);
    logic [m*o-1:0] rx;
    logic [m-1:0]   rx_rdy;
    logic [m-1:0]   rx_pop;
    logic [n*m-1:0] lut;
    logic [n-1:0]   tx_afull;
    logic [o-1:0]   tx;
    logic [n-1:0]   tx_cke;
    logic [m-1:0]   rx_drop;

    modport master (
        output rx, rx_rdy, lut, tx_afull,
        input  rx_pop, tx, tx_cke, rx_drop
    );

    modport slave (
        input  rx, rx_rdy, lut, tx_afull,
        output rx_pop, tx, tx_cke, rx_drop
    );
endinterface

// File: rtl/data_matrix_rr_arbiter.sv
// Combinational work-conserving round-robin arbiter.
// Searches ptr, ptr+1, ... modulo m and grants the first requester.
module rr_arbiter #(
    parameter int m = 8,
    localparam int pw = (m > 1) ? $clog2(m) : 1
) (
    input  logic [m-1:0]  req,
    input  logic [pw-1:0] ptr,
    output logic [m-1:0]  gnt,
    output logic [pw-1:0] gnt_idx,
    output logic          gnt_vld
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int k = 0; k < m; k++) begin
            idx = int'(ptr) + k;
            if (idx >= m) begin
                idx = idx - m;
            end
            if (!gnt_vld && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = pw'(idx);
            end
        end
    end

endmodule

// File: rtl/data_matrix_rr.sv
// Round-robin crossbar from m RX FIFOs to n TX FIFOs on a shared data bus.
// Grant is combinational; pop, data and write enables are registered.
module data_matrix_rr
    import data_matrix_rr_pkg::*;
#(
    parameter int m    = 8,
    parameter int n    = 8,
    parameter int o    = 8,
    parameter int DROP = POLICY_STALL
) (
    input logic              clk,
    input logic              rst,
    data_matrix_rr_if.slave  bus
);

    localparam int pw      = $clog2(m);
    localparam bit drop_en = (DROP == POLICY_DROP);

    logic [m-1:0]  req;
    logic [m-1:0]  gnt;
    logic [pw-1:0] gnt_idx;
    logic          gnt_vld;
    logic [pw-1:0] ptr;
    logic [n-1:0]  row_g;
    logic [o-1:0]  data_g;

    logic [m-1:0]  pop_q;
    logic [m-1:0]  drop_q;
    logic [n-1:0]  cke_q;
    logic [o-1:0]  tx_q;

    // An input whose pop is still in flight is masked so its FIFO can update.
    always_comb begin
        req = '0;
        for (int i = 0; i < m; i++) begin
            req[i] = bus.rx_rdy[i] && !pop_q[i] &&
                     (drop_en || ((bus.lut[i*n +: n] & bus.tx_afull) == '0));
        end
    end

    rr_arbiter #(.m(m)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        row_g  = '0;
        data_g = '0;
        for (int i = 0; i < m; i++) begin
            if (gnt[i]) begin
                row_g  = bus.lut[i*n +: n];
                data_g = bus.rx[i*o +: o];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_q  <= '0;
            drop_q <= '0;
            cke_q  <= '0;
            tx_q   <= '0;
            ptr    <= '0;
        end else begin
            pop_q  <= gnt;
            drop_q <= '0;
            cke_q  <= '0;
            if (gnt_vld) begin
                tx_q  <= data_g;
                cke_q <= drop_en ? (row_g & ~bus.tx_afull) : row_g;
                if (drop_en && |(row_g & bus.tx_afull)) begin
                    drop_q <= gnt;
                end
                ptr <= pw'(next_ptr(int'(gnt_idx), m));
            end
        end
    end

    assign bus.rx_pop  = pop_q;
    assign bus.rx_drop = drop_q;
    assign bus.tx_cke  = cke_q;
    assign bus.tx      = tx_q;

endmodule

// File: tb/tb_data_matrix_rr.sv
// Bench for data_matrix_rr: stall (DROP=0) and drop (DROP=1) instances
// driven with identical stimulus from a vector table plus a reset sequence.
module tb_data_matrix_rr;

    localparam int M = 4;
    localparam int N = 4;
    localparam int O = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_matrix_rr_if #(.m(M), .n(N), .o(O)) bus0 ();
    data_matrix_rr_if #(.m(M), .n(N), .o(O)) bus1 ();

    data_matrix_rr #(.m(M), .n(N), .o(O), .DROP(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    data_matrix_rr #(.m(M), .n(N), .o(O), .DROP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic       pre_rst;
        logic [3:0] rdy;
        logic [3:0] afull;
        logic [15:0] lut;
        logic [3:0] p0, c0, d0;
        logic [3:0] p1, c1, d1;
    } vec_t;

    typedef struct {
        logic [3:0] pop;
        logic [3:0] cke;
        logic [3:0] drop;
        logic [7:0] tx;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic pr, input logic [3:0] rdy, input logic [3:0] af,
                                input logic [15:0] lut,
                                input logic [3:0] p0, input logic [3:0] c0, input logic [3:0] d0,
                                input logic [3:0] p1, input logic [3:0] c1, input logic [3:0] d1);
        vec_t v;
        v.pre_rst = pr; v.rdy = rdy; v.afull = af; v.lut = lut;
        v.p0 = p0; v.c0 = c0; v.d0 = d0;
        v.p1 = p1; v.c1 = c1; v.d1 = d1;
        return v;
    endfunction

    // Granted input i carries data 8'hA0 + i; with no grant the bus holds.
    function automatic logic [7:0] tx_for(input logic [3:0] pop, input logic [7:0] last);
        logic [7:0] r;
        r = last;
        for (int i = 0; i < 4; i++) begin
            if (pop[i]) r = 8'hA0 + 8'(i);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] rdy, input logic [3:0] af, input logic [15:0] lut);
        bus0.rx_rdy = rdy; bus0.tx_afull = af; bus0.lut = lut;
        bus1.rx_rdy = rdy; bus1.tx_afull = af; bus1.lut = lut;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " dut0 pop"},  {4'b0, bus0.rx_pop},  8'h00);
        chk({tag, " dut0 cke"},  {4'b0, bus0.tx_cke},  8'h00);
        chk({tag, " dut0 drop"}, {4'b0, bus0.rx_drop}, 8'h00);
        chk({tag, " dut0 tx"},   bus0.tx,              8'h00);
        chk({tag, " dut1 pop"},  {4'b0, bus1.rx_pop},  8'h00);
        chk({tag, " dut1 cke"},  {4'b0, bus1.tx_cke},  8'h00);
        chk({tag, " dut1 drop"}, {4'b0, bus1.rx_drop}, 8'h00);
        chk({tag, " dut1 tx"},   bus1.tx,              8'h00);
    endtask

    initial begin
        vec_t v[19];
        exp_t e0, e1;
        logic [7:0] last0, last1;
        string tag;

        // A: all ready, rows 0001 -> rotate 0,1,2,3,0,1
        v[0]  = mk(1, 4'b1111, 4'b0000, 16'h1111, 4'b0001, 4'b0001, 0, 4'b0001, 4'b0001, 0);
        v[1]  = mk(0, 4'b1111, 4'b0000, 16'h1111, 4'b0010, 4'b0001, 0, 4'b0010, 4'b0001, 0);
        v[2]  = mk(0, 4'b1111, 4'b0000, 16'h1111, 4'b0100, 4'b0001, 0, 4'b0100, 4'b0001, 0);
        v[3]  = mk(0, 4'b1111, 4'b0000, 16'h1111, 4'b1000, 4'b0001, 0, 4'b1000, 4'b0001, 0);
        v[4]  = mk(0, 4'b1111, 4'b0000, 16'h1111, 4'b0001, 4'b0001, 0, 4'b0001, 4'b0001, 0);
        v[5]  = mk(0, 4'b1111, 4'b0000, 16'h1111, 4'b0010, 4'b0001, 0, 4'b0010, 4'b0001, 0);
        // B: only 1 and 3 ready -> 1,3,1 with no idle cycles
        v[6]  = mk(1, 4'b1010, 4'b0000, 16'h1111, 4'b0010, 4'b0001, 0, 4'b0010, 4'b0001, 0);
        v[7]  = mk(0, 4'b1010, 4'b0000, 16'h1111, 4'b1000, 4'b0001, 0, 4'b1000, 4'b0001, 0);
        v[8]  = mk(0, 4'b1010, 4'b0000, 16'h1111, 4'b0010, 4'b0001, 0, 4'b0010, 4'b0001, 0);
        // C: row0 0011, row1 0100, tx_afull[1] high then low
        v[9]  = mk(1, 4'b0011, 4'b0010, 16'h0043, 4'b0010, 4'b0100, 0, 4'b0001, 4'b0001, 4'b0001);
        v[10] = mk(0, 4'b0011, 4'b0010, 16'h0043, 4'b0000, 4'b0000, 0, 4'b0010, 4'b0100, 0);
        v[11] = mk(0, 4'b0011, 4'b0010, 16'h0043, 4'b0010, 4'b0100, 0, 4'b0001, 4'b0001, 4'b0001);
        v[12] = mk(0, 4'b0011, 4'b0010, 16'h0043, 4'b0000, 4'b0000, 0, 4'b0010, 4'b0100, 0);
        v[13] = mk(0, 4'b0011, 4'b0000, 16'h0043, 4'b0001, 4'b0011, 0, 4'b0001, 4'b0011, 0);
        // D: input 2 with an empty row is flushed, even with every output full
        v[14] = mk(1, 4'b0100, 4'b0000, 16'h0000, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 0);
        v[15] = mk(0, 4'b0100, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
        v[16] = mk(0, 4'b0100, 4'b0000, 16'h0000, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 0);
        v[17] = mk(0, 4'b0100, 4'b1111, 16'h0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
        v[18] = mk(0, 4'b0100, 4'b1111, 16'h0000, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 0);

        bus0.rx = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus1.rx = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        drive(4'b0000, 4'b0000, 16'h0000);
        last0 = 8'h00;
        last1 = 8'h00;

        #2;
        chk_zero("reset");
        #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 19; k++) begin
            if (v[k].pre_rst) begin
                rst = 1'b1;
                #2 rst = 1'b0;
                last0 = 8'h00;
                last1 = 8'h00;
            end
            drive(v[k].rdy, v[k].afull, v[k].lut);
            e0.pop = v[k].p0; e0.cke = v[k].c0; e0.drop = v[k].d0;
            e0.tx = tx_for(v[k].p0, last0); last0 = e0.tx;
            e1.pop = v[k].p1; e1.cke = v[k].c1; e1.drop = v[k].d1;
            e1.tx = tx_for(v[k].p1, last1); last1 = e1.tx;
            q0.push_back(e0);
            q1.push_back(e1);

            @(posedge clk); #1;
            tag = $sformatf("v%0d", k);
            if (q0.size() == 0 || q1.size() == 0) begin
                chk({tag, " scoreboard empty"}, 8'h01, 8'h00);
            end else begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                chk({tag, " dut0 pop"},  {4'b0, bus0.rx_pop},  {4'b0, e0.pop});
                chk({tag, " dut0 cke"},  {4'b0, bus0.tx_cke},  {4'b0, e0.cke});
                chk({tag, " dut0 drop"}, {4'b0, bus0.rx_drop}, {4'b0, e0.drop});
                chk({tag, " dut0 tx"},   bus0.tx,              e0.tx);
                chk({tag, " dut1 pop"},  {4'b0, bus1.rx_pop},  {4'b0, e1.pop});
                chk({tag, " dut1 cke"},  {4'b0, bus1.tx_cke},  {4'b0, e1.cke});
                chk({tag, " dut1 drop"}, {4'b0, bus1.rx_drop}, {4'b0, e1.drop});
                chk({tag, " dut1 tx"},   bus1.tx,              e1.tx);
            end
        end

        // Reset mid-transfer: ptr is 3 here, so input 1 wins first.
        drive(4'b0010, 4'b0000, 16'h1111);
        @(posedge clk); #1;
        chk("midrst pre dut0 pop", {4'b0, bus0.rx_pop}, 8'h02);
        chk("midrst pre dut1 pop", {4'b0, bus1.rx_pop}, 8'h02);
        #2 rst = 1'b1;
        #1 chk_zero("midrst");
        #1 rst = 1'b0;
        drive(4'b1111, 4'b0000, 16'h1111);
        @(posedge clk); #1;
        chk("post rst dut0 pop", {4'b0, bus0.rx_pop}, 8'h01);
        chk("post rst dut1 pop", {4'b0, bus1.rx_pop}, 8'h01);
        chk("post rst dut0 tx",  bus0.tx,             8'hA0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
